// File: rtl/tick_scheduler.sv
// Programmable tick generator: issues a pulse every divisor+1 clocks for a configured
// number of ticks (or forever), toggling output_clock on each tick.
module tick_scheduler #(
    parameter int unsigned DEFAULT_DIVISOR = 8333333,
    parameter int unsigned DIV_W           = 25
) (
    input  logic             input_clock,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_divisor,
    input  logic [7:0]       cfg_count,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             output_clock,
    output logic [7:0]       tick_index,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] counter_q, counter_d;
    logic [DIV_W-1:0] divisor_q, divisor_d;
    logic [7:0]       count_q, count_d;
    logic [7:0]       tickIndex_q, tickIndex_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             outClk_q, outClk_d;
    logic             busy_q;
    logic             cfgReady_q;
    logic [7:0]       nextIndex;

    assign nextIndex = tickIndex_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        divisor_d   = divisor_q;
        count_d     = count_q;
        tickIndex_d = tickIndex_q;
        tick_d      = 1'b0;
        done_d      = 1'b0;
        outClk_d    = outClk_q;
        case (state_q)
            IDLE: begin
                // A zero divisor would give a one-cycle period, so it is promoted to 1.
                if (cfg_valid && cfgReady_q) begin
                    divisor_d = (cfg_divisor == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : cfg_divisor;
                    count_d   = cfg_count;
                end
                if (start) begin
                    state_d     = RUN;
                    counter_d   = '0;
                    tickIndex_d = 8'd0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d   = IDLE;
                    counter_d = '0;
                end else if (counter_q == divisor_q) begin
                    counter_d   = '0;
                    tick_d      = 1'b1;
                    outClk_d    = ~outClk_q;
                    tickIndex_d = nextIndex;
                    if ((count_q != 8'd0) && (nextIndex == count_q)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    counter_d = counter_q + {{(DIV_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // busy and cfg_ready are registered from the next state so they line up with state_q.
    always_ff @(posedge input_clock) begin
        if (reset) begin
            state_q     <= IDLE;
            counter_q   <= '0;
            divisor_q   <= DIV_W'(DEFAULT_DIVISOR);
            count_q     <= 8'd0;
            tickIndex_q <= 8'd0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
            outClk_q    <= 1'b0;
            busy_q      <= 1'b0;
            cfgReady_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            divisor_q   <= divisor_d;
            count_q     <= count_d;
            tickIndex_q <= tickIndex_d;
            tick_q      <= tick_d;
            done_q      <= done_d;
            outClk_q    <= outClk_d;
            busy_q      <= (state_d != IDLE);
            cfgReady_q  <= (state_d == IDLE);
        end
    end

    assign cfg_ready    = cfgReady_q;
    assign tick         = tick_q;
    assign done         = done_q;
    assign output_clock = outClk_q;
    assign tick_index   = tickIndex_q;
    assign busy         = busy_q;

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 The block SHALL have parameter DEFAULT_DIVISOR, default 8333333, giving the divisor loaded at reset.
REQ-002 The block SHALL have parameter DIV_W, default 25, giving the divisor and counter width.
REQ-003 input_clock  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cfg_valid  input  1  configuration offered.
REQ-006 cfg_ready  output  1  configuration acceptable.
REQ-007 cfg_divisor  input  DIV_W  tick period minus one, in input_clock cycles.
REQ-008 cfg_count  input  8  ticks per run; 0 means free-run.
REQ-009 start  input  1  begin a run; level-sampled.
REQ-010 stop  input  1  abort a run; level-sampled.
REQ-011 tick  output  1  one-cycle pulse per elapsed period.
REQ-012 output_clock  output  1  toggles on every tick.
REQ-013 tick_index  output  8  ticks issued in the current run.
REQ-014 busy  output  1  high when state is not IDLE.
REQ-015 done  output  1  one-cycle pulse on run completion.

Function
REQ-016 The FSM SHALL have three states, IDLE, RUN and DONE, with all outputs registered.
REQ-017 cfg_ready SHALL equal (state==IDLE), and a configuration SHALL be accepted only when cfg_valid and cfg_ready are both high.
REQ-018 An accepted configuration SHALL latch the divisor and count registers at that edge; a cfg_divisor of 0 SHALL be stored as 1.
REQ-019 start in IDLE SHALL cause state RUN, counter 0 and tick_index 0 at the next edge.
REQ-020 When start and a cfg handshake occur in the same cycle, the run SHALL use the new configuration.
REQ-021 In RUN, the counter SHALL increment each cycle; when it equals the divisor register, the counter SHALL return to 0, tick SHALL be high for the next cycle, output_clock SHALL toggle, and tick_index SHALL increment.
REQ-022 The first tick SHALL be high in cycle start_edge+D+1, where D is the divisor register; subsequent ticks SHALL occur every D+1 cycles.
REQ-023 When the count register is nonzero and a tick brings tick_index to the count register value, state SHALL become DONE, with done high coincident with that final tick, and state SHALL return to IDLE at the next edge.
REQ-024 When the count register is 0, the run SHALL be free-running: tick_index wraps 255->0 and done is never asserted.
REQ-025 stop in RUN SHALL cause state IDLE at the next edge with the counter cleared, and output_clock and tick_index held.
REQ-026 When stop and a terminal counter value coincide, stop SHALL win: no tick, no toggle and no done.
REQ-027 start in RUN or DONE SHALL be ignored, and cfg_valid outside IDLE SHALL be ignored.
REQ-028 stop in IDLE or DONE SHALL be ignored, and DONE SHALL always return to IDLE.
REQ-029 tick and done SHALL never be high for more than one consecutive cycle, except that tick SHALL be high every cycle when D=1 is not possible (minimum period 2 cycles).

Reset
REQ-030 While reset is high, state SHALL be IDLE, counter 0, divisor register DEFAULT_DIVISOR, count register 0, tick 0, done 0, busy 0, tick_index 0 and output_clock 0.
REQ-031 Reset SHALL take priority over all inputs and SHALL abort a run in progress without asserting done.

Verification (DEFAULT_DIVISOR=3 for the bench)
REQ-032 The bench SHALL cover reset followed by a single-cycle start with no configuration: ticks at cycles 4, 8 and 12 after start, output_clock 1,0,1, and done never asserted.
REQ-033 The bench SHALL cover configuration divisor=2, count=3 followed by start: ticks at +3, +6 and +9 cycles, done coincident with the third tick, busy low one cycle later, and tick_index=3 held.
REQ-034 The bench SHALL cover cfg_divisor=0 with count=2: period of 2 cycles, 2 ticks, then done.
REQ-035 The bench SHALL cover stop asserted on the cycle where the counter equals the divisor: no tick, busy low at the next edge, and output_clock unchanged.
REQ-036 The bench SHALL cover cfg_valid together with start in RUN: cfg_ready=0, the configuration is unchanged, and the run is unaffected; the bench SHALL also cover reset pulsed mid-run, after which all outputs are 0 and done is never asserted.
REQ-037 The bench SHALL cover free-run with divisor=1 for 600 cycles: tick every 2nd cycle, tick_index wrapping 255->0, and done never asserted.
